mips_irq_ctrl: RTL and testbench

Parametrised multi-channel interrupt controller feeding the single `interrupt` input of the MIPS core. It synchronises up to NUM_IRQ external request lines, latches them as edge- or level-sensitive per channel, applies a software mask, and selects the highest-priority unmasked request. It then drives a request/acknowledge/end-of-interrupt handshake with the core and supplies the vector address (the core's `current_address` width) for the selected channel.

---
 rtl/mips_irq_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mips_irq_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_irq_ctrl.sv
// mips_irq_ctrl
//    Interrupt controller for the single MIPS core `interrupt` input.
//    Each external request line passes through a two-flop synchroniser.
//    Depending on EDGE_MASK, the channel is then latched as a rising edge
//    or passed through as a level. The result is masked, and the
//    lowest-index eligible channel is selected. The selected channel is
//    presented to the core through a req/ack/eoi handshake, together with
//    its vector address.
//
// Ports
//    clk        system clock, rising edge
//    reset      asynchronous, active-high; clears all state
//    irq_in     raw asynchronous request lines
//    mask_wr    mask register write strobe
//    mask_data  new mask value (1 = masked)
//    irq_ack    core accepted the request (pulse)
//    eoi        core finished the handler (pulse)
//    irq_req    request to the core
//    vec_addr   handler address of the selected channel
//    irq_id     selected channel index
//    pending    pending bits before masking
//    mask       current mask register
//    busy       high while a request is outstanding or in service
//
// FSM states
//    state      | meaning
//    ST_IDLE    | waiting for an eligible request; selects the winner
//    ST_REQ     | irq_req high, waiting for irq_ack
//    ST_SERVICE | handler running, waiting for eoi

module mips_irq_ctrl #(
    parameter int                   NUM_IRQ    = 8,
    parameter int                   ADDR_W     = 8,
    parameter logic [ADDR_W-1:0]    VEC_BASE   = 8'hE0,
    parameter int                   VEC_STRIDE = 4,
    parameter logic [NUM_IRQ-1:0]   EDGE_MASK  = '1,
    localparam int                  ID_W       = (NUM_IRQ > 2) ? $clog2(NUM_IRQ) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_IRQ-1:0]  irq_in,
    input  logic                mask_wr,
    input  logic [NUM_IRQ-1:0]  mask_data,
    input  logic                irq_ack,
    input  logic                eoi,
    output logic                irq_req,
    output logic [ADDR_W-1:0]   vec_addr,
    output logic [ID_W-1:0]     irq_id,
    output logic [NUM_IRQ-1:0]  pending,
    output logic [NUM_IRQ-1:0]  mask,
    output logic                busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_SERVICE
    } state_t;

    state_t               state_q,   state_d;
    logic [NUM_IRQ-1:0]   s1_q,      s1_d;
    logic [NUM_IRQ-1:0]   s2_q,      s2_d;
    logic [NUM_IRQ-1:0]   s2_prev_q, s2_prev_d;
    logic [NUM_IRQ-1:0]   pend_q,    pend_d;
    logic [NUM_IRQ-1:0]   mask_q,    mask_d;
    logic [ID_W-1:0]      id_q,      id_d;
    logic [ADDR_W-1:0]    vec_q,     vec_d;

    logic [NUM_IRQ-1:0]   edge_set;
    logic [NUM_IRQ-1:0]   pending_w;
    logic [NUM_IRQ-1:0]   eligible;
    logic [NUM_IRQ-1:0]   ack_clr;
    logic [ID_W-1:0]      winner;
    logic [ADDR_W-1:0]    vec_sel;

    // Input path, pending and mask
    always_comb begin
        s1_d      = irq_in;
        s2_d      = s1_q;
        s2_prev_d = s2_q;

        edge_set  = s2_q & ~s2_prev_q & EDGE_MASK;
        // The edge being latched this cycle is already reported, so pending
        // becomes visible on the same edge that the synchroniser output rises.
        pending_w = (EDGE_MASK & (pend_q | edge_set)) | (~EDGE_MASK & s2_q);
        eligible  = pending_w & ~mask_q;

        // Scan from high to low so that the lowest eligible index is the
        // last one written.
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = ID_W'(i);
            end
        end
        vec_sel = VEC_BASE + ADDR_W'(winner) * ADDR_W'(VEC_STRIDE);

        mask_d = mask_wr ? mask_data : mask_q;

        // A new edge arriving in the same cycle as the ack re-arms the
        // channel, because the set term is applied after the clear.
        pend_d = ((pend_q & ~ack_clr) | edge_set) & EDGE_MASK;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        vec_d   = vec_q;
        ack_clr = '0;
        case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    id_d    = winner;
                    vec_d   = vec_sel;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    for (int i = 0; i < NUM_IRQ; i++) begin
                        if (ID_W'(i) == id_q) begin
                            ack_clr[i] = 1'b1;
                        end
                    end
                    state_d = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (eoi) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            s1_q      <= '0;
            s2_q      <= '0;
            s2_prev_q <= '0;
            pend_q    <= '0;
            mask_q    <= '1;
            id_q      <= '0;
            vec_q     <= VEC_BASE;
        end else begin
            state_q   <= state_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s2_prev_q <= s2_prev_d;
            pend_q    <= pend_d;
            mask_q    <= mask_d;
            id_q      <= id_d;
            vec_q     <= vec_d;
        end
    end

    assign irq_req  = (state_q == ST_REQ);
    assign busy     = (state_q != ST_IDLE);
    assign irq_id   = id_q;
    assign vec_addr = vec_q;
    assign pending  = pending_w;
    assign mask     = mask_q;

endmodule

// File: tb/tb_mips_irq_ctrl.sv
module tb_mips_irq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irq_in;
    logic       mask_wr;
    logic [7:0] mask_data;
    logic       irq_ack;
    logic       eoi;
    logic       irq_req;
    logic [7:0] vec_addr;
    logic [2:0] irq_id;
    logic [7:0] pending;
    logic [7:0] mask;
    logic       busy;

    int total = 0;
    int bad   = 0;

    // Channel 1 is level-sensitive, all others edge-sensitive.
    mips_irq_ctrl #(
        .NUM_IRQ    (8),
        .ADDR_W     (8),
        .VEC_BASE   (8'hE0),
        .VEC_STRIDE (4),
        .EDGE_MASK  (8'hFD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_in    (irq_in),
        .mask_wr   (mask_wr),
        .mask_data (mask_data),
        .irq_ack   (irq_ack),
        .eoi       (eoi),
        .irq_req   (irq_req),
        .vec_addr  (vec_addr),
        .irq_id    (irq_id),
        .pending   (pending),
        .mask      (mask),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_mask(input logic [7:0] v);
        mask_wr   = 1'b1;
        mask_data = v;
        step();
        mask_wr   = 1'b0;
    endtask

    task automatic wait_req();
        for (int k = 0; k < 20 && irq_req !== 1'b1; k++) step();
        chk("wait_req", irq_req, 1);
    endtask

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [7:0] vec_of(input int id);
        logic [7:0] r;
        r = 8'(8'hE0 + id * 4);
        return r;
    endfunction

    logic [7:0] pend_model;
    logic [7:0] p, mv, elig;
    int         id;
    logic       both;

    initial begin
        reset = 1'b1; irq_in = '0; mask_wr = 1'b0; mask_data = '0;
        irq_ack = 1'b0; eoi = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
        chk("rst_req",  irq_req, 0);
        chk("rst_id",   irq_id, 0);
        chk("rst_vec",  vec_addr, 8'hE0);
        chk("rst_pend", pending, 0);
        chk("rst_mask", mask, 8'hFF);
        chk("rst_busy", busy, 0);

        // single edge request on channel 3, 3-edge latency
        write_mask(8'h00);
        chk("mask00", mask, 8'h00);
        irq_in = 8'h08;
        step(); chk("t1_n0_req", irq_req, 0);
        step(); chk("t1_n1_req", irq_req, 0); chk("t1_n1_pend", pending[3], 1);
        step(); chk("t1_n2_req", irq_req, 1);
        irq_in = 8'h00;
        chk("t1_id", irq_id, 3); chk("t1_vec", vec_addr, 8'hEC); chk("t1_busy", busy, 1);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        chk("t1_ack_req", irq_req, 0); chk("t1_ack_pend", pending[3], 0); chk("t1_ack_busy", busy, 1);
        eoi = 1'b1; step(); eoi = 1'b0;
        chk("t1_eoi_busy", busy, 0);

        // simultaneous channels 5 and 2
        irq_in = 8'h24;
        step(); step(); step();
        irq_in = 8'h00;
        chk("t2_req", irq_req, 1); chk("t2_id", irq_id, 2); chk("t2_vec", vec_addr, 8'hE8);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        eoi = 1'b1; step(); eoi = 1'b0;
        chk("t2_idle_req", irq_req, 0);
        step();
        chk("t2b_req", irq_req, 1); chk("t2b_id", irq_id, 5); chk("t2b_vec", vec_addr, 8'hF4);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        eoi = 1'b1; step(); eoi = 1'b0;

        // masked request stays pending, unmask releases it
        write_mask(8'h04);
        irq_in = 8'h04;
        step(); step(); step();
        irq_in = 8'h00;
        step(); step();
        chk("t3_noreq", irq_req, 0); chk("t3_pend", pending[2], 1);
        write_mask(8'h00);
        chk("t3_m_req", irq_req, 0);
        step();
        chk("t3_req", irq_req, 1); chk("t3_id", irq_id, 2);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        eoi = 1'b1; step(); eoi = 1'b0;

        // level channel 1
        irq_in = 8'h02;
        step(); step(); step();
        chk("t4_req", irq_req, 1); chk("t4_id", irq_id, 1); chk("t4_vec", vec_addr, 8'hE4);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        chk("t4_lvl_pend", pending[1], 1);
        eoi = 1'b1; step(); eoi = 1'b0;
        chk("t4_eoi_req", irq_req, 0);
        step();
        chk("t4_rereq", irq_req, 1);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        irq_in = 8'h00;
        step(); step();
        eoi = 1'b1; step(); eoi = 1'b0;
        step(); step();
        chk("t4_norereq", irq_req, 0); chk("t4_busy", busy, 0);

        // new edge on channel 3 in the same cycle as its ack
        irq_in = 8'h08;
        step(); step(); step();
        chk("t5_req", irq_req, 1);
        irq_in = 8'h00;
        step(); step(); step();
        irq_in = 8'h08;
        step(); step();
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        irq_in = 8'h00;
        chk("t5_ack_req", irq_req, 0); chk("t5_pend_kept", pending[3], 1);
        eoi = 1'b1; step(); eoi = 1'b0;
        step();
        chk("t5_rereq", irq_req, 1); chk("t5_id", irq_id, 3);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        chk("t5_pend_clr", pending[3], 0);
        eoi = 1'b1; step(); eoi = 1'b0;

        // ack and eoi in IDLE are ignored
        irq_ack = 1'b1; eoi = 1'b1; step(); irq_ack = 1'b0; eoi = 1'b0;
        chk("idle_ack_busy", busy, 0);

        // asynchronous reset while in REQ
        irq_in = 8'h50;
        step(); step(); step();
        irq_in = 8'h00;
        chk("t6_req", irq_req, 1); chk("t6_id", irq_id, 4);
        reset = 1'b1;
        #1;
        chk("t6_req_rst",  irq_req, 0);
        chk("t6_pend_rst", pending, 0);
        chk("t6_mask_rst", mask, 8'hFF);
        chk("t6_vec_rst",  vec_addr, 8'hE0);
        chk("t6_id_rst",   irq_id, 0);
        chk("t6_busy_rst", busy, 0);
        step();
        reset = 1'b0;
        write_mask(8'h00);
        step(); step(); step();
        chk("t6_noreplay", irq_req, 0);

        // randomized rounds against a transaction-level model
        pend_model = 8'h00;
        for (int r = 0; r < 20; r++) begin
            write_mask(8'hFF);
            p = 8'($urandom) & 8'hFD;
            irq_in = p;
            step(); step(); step();
            irq_in = 8'h00;
            step(); step(); step();
            pend_model = pend_model | p;
            chk("rnd_pend", pending, pend_model);
            chk("rnd_idle", irq_req, 0);
            mv = 8'($urandom);
            write_mask(mv);
            elig = pend_model & ~mv;
            while (elig != 8'h00) begin
                id = lowest(elig);
                wait_req();
                chk("rnd_id", irq_id, id);
                chk("rnd_vec", vec_addr, vec_of(id));
                both = 1'($urandom);
                irq_ack = 1'b1; eoi = both;
                step();
                irq_ack = 1'b0; eoi = 1'b0;
                pend_model[id] = 1'b0;
                chk("rnd_ack_req", irq_req, 0);
                chk("rnd_ack_busy", busy, 1);
                chk("rnd_ack_pend", pending, pend_model);
                eoi = 1'b1; step(); eoi = 1'b0;
                chk("rnd_eoi_busy", busy, 0);
                elig = pend_model & ~mv;
            end
            step(); step();
            chk("rnd_done_req", irq_req, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
